// File: rtl/add_round_key_stream.sv
// Streaming AddRoundKey stage: XORs state with a round subkey, tags each beat with
// its round index and buffers results in a small circular FIFO for backpressure.
module add_round_key_stream #(
  parameter int NB    = 4,
  parameter int NR    = 10,
  parameter int DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [32*NB-1:0]             in_state,
  input  logic [32*NB-1:0]             in_key,
  input  logic                         in_first,
  input  logic                         bypass,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [32*NB-1:0]             out_state,
  output logic [$clog2(NR+1)-1:0]      out_round,
  output logic                         out_last,
  output logic                         done,
  output logic                         err,
  output logic [$clog2(DEPTH+1)-1:0]   level
);

  localparam int DW = 32 * NB;
  localparam int RW = $clog2(NR + 1);
  localparam int LW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);

  localparam logic [RW-1:0] LAST_TAG = RW'(NR);
  localparam logic [LW-1:0] FULL     = LW'(DEPTH);

  logic [DW-1:0] data_q  [DEPTH];
  logic [RW-1:0] round_q [DEPTH];

  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [LW-1:0] level_q;

  logic          idle_q;
  logic [RW-1:0] exp_q;
  logic          err_q;
  logic          done_q;

  logic          accept;
  logic          pop;
  logic [RW-1:0] tag;
  logic [DW-1:0] result;
  logic [DW-1:0] head_state;
  logic [RW-1:0] head_round;

  // in_ready depends on occupancy only, so downstream ready never ripples upstream.
  assign in_ready  = (level_q < FULL);
  assign out_valid = (level_q != '0);
  assign accept    = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  // A beat starting a block, or arriving while no block is open, is round 0.
  assign tag    = (in_first || idle_q) ? '0 : exp_q;
  assign result = bypass ? in_state : (in_state ^ in_key);

  assign head_state = data_q[rd_ptr];
  assign head_round = round_q[rd_ptr];

  // Head fields are forced to zero when empty so stale storage never leaks out.
  assign out_state = out_valid ? head_state : '0;
  assign out_round = out_valid ? head_round : '0;
  assign out_last  = out_valid && (head_round == LAST_TAG);

  assign done  = done_q;
  assign err   = err_q;
  assign level = level_q;

  // NOTE: buffer storage has no reset; out_valid gating hides its contents when empty.
  always_ff @(posedge clk) begin
    if (accept) begin
      data_q[wr_ptr]  <= result;
      round_q[wr_ptr] <= tag;
    end
  end

  // NOTE: all state below uses non-blocking assignments so every register samples
  // pre-edge values, independent of statement order within the block.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level_q <= '0;
      idle_q  <= 1'b1;
      exp_q   <= '0;
      err_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= pop && out_last;

      if (accept) begin
        wr_ptr <= wr_ptr + PW'(1);
        if (tag == LAST_TAG) begin
          idle_q <= 1'b1;
        end else begin
          idle_q <= 1'b0;
          exp_q  <= tag + RW'(1);
        end
        if (!in_first && idle_q) begin
          err_q <= 1'b1;
        end
      end

      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end

      case ({accept, pop})
        2'b10:   level_q <= level_q + LW'(1);
        2'b01:   level_q <= level_q - LW'(1);
        default: level_q <= level_q;
      endcase
    end
  end

endmodule

// File: tb/tb_add_round_key_stream.sv
// Bench for add_round_key_stream: queue-based reference model checked every cycle,
// plus directed vectors (FIPS-197 round 0, block sequencing, backpressure, reset, NB=8).
module tb_add_round_key_stream;

  localparam int NR    = 10;
  localparam int DEPTH = 2;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  // NB=4 instance
  logic         in_valid, in_first, bypass, out_ready;
  logic [127:0] in_state, in_key;
  logic         in_ready, out_valid, out_last, done, err;
  logic [127:0] out_state;
  logic [3:0]   out_round;
  logic [1:0]   level;

  // NB=8 instance
  logic         w_in_valid, w_in_first, w_bypass, w_out_ready;
  logic [255:0] w_in_state, w_in_key;
  logic         w_in_ready, w_out_valid, w_out_last, w_done, w_err;
  logic [255:0] w_out_state;
  logic [3:0]   w_out_round;
  logic [1:0]   w_level;

  add_round_key_stream #(.NB(4), .NR(NR), .DEPTH(DEPTH)) dut4 (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_state(in_state), .in_key(in_key),
    .in_first(in_first), .bypass(bypass),
    .out_valid(out_valid), .out_ready(out_ready), .out_state(out_state),
    .out_round(out_round), .out_last(out_last), .done(done), .err(err), .level(level)
  );

  add_round_key_stream #(.NB(8), .NR(NR), .DEPTH(DEPTH)) dut8 (
    .clk(clk), .reset(reset),
    .in_valid(w_in_valid), .in_ready(w_in_ready), .in_state(w_in_state), .in_key(w_in_key),
    .in_first(w_in_first), .bypass(w_bypass),
    .out_valid(w_out_valid), .out_ready(w_out_ready), .out_state(w_out_state),
    .out_round(w_out_round), .out_last(w_out_last), .done(w_done), .err(w_err),
    .level(w_level)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, req);
    end
  endtask

  // ---------------- reference model (NB=4 instance) ----------------
  typedef struct {
    logic [127:0] st;
    int           rnd;
    bit           last;
  } entry_t;

  entry_t q[$];
  bit     m_idle = 1'b1;
  int     m_exp  = 0;
  bit     m_err  = 1'b0;
  bit     m_done = 1'b0;
  bit     m_acc, m_pop;
  int     m_tag;

  function automatic logic [127:0] ark_bytes(input logic [127:0] s, input logic [127:0] k,
                                             input bit byp);
    logic [127:0] r;
    r = '0;
    for (int c = 0; c < 4; c++) begin
      for (int row = 0; row < 4; row++) begin
        int b;
        b = 127 - 8 * (4 * c + row);
        r[b -: 8] = byp ? s[b -: 8] : (s[b -: 8] ^ k[b -: 8]);
      end
    end
    return r;
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      q.delete();
      m_idle = 1'b1;
      m_exp  = 0;
      m_err  = 1'b0;
      m_done = 1'b0;
    end else begin
      m_acc  = in_valid && (q.size() < DEPTH);
      m_pop  = (q.size() > 0) && out_ready;
      m_done = m_pop && q[0].last;
      if (m_pop) void'(q.pop_front());
      if (m_acc) begin
        m_tag = (in_first || m_idle) ? 0 : m_exp;
        if (!in_first && m_idle) m_err = 1'b1;
        if (m_tag == NR) m_idle = 1'b1;
        else begin
          m_exp  = m_tag + 1;
          m_idle = 1'b0;
        end
        q.push_back('{st: ark_bytes(in_state, in_key, bypass), rnd: m_tag, last: (m_tag == NR)});
      end
    end
  end

  entry_t h;
  bit     hv;
  always @(negedge clk) begin
    hv = (q.size() != 0);
    if (hv) h = q[0];
    else    h = '{st: '0, rnd: 0, last: 1'b0};
    check("cmp_out_valid", out_valid, hv);
    check("cmp_level",     level,     q.size());
    check("cmp_in_ready",  in_ready,  q.size() < DEPTH);
    check("cmp_out_state", out_state, h.st);
    check("cmp_out_round", out_round, h.rnd);
    check("cmp_out_last",  out_last,  h.last);
    check("cmp_done",      done,      m_done);
    check("cmp_err",       err,       m_err);
  end

  // ---------------- stimulus ----------------
  function automatic logic [127:0] pat_s(input int k);
    return {16{8'(k * 29 + 7)}} ^ 128'h0123456789abcdeffedcba9876543210;
  endfunction

  function automatic logic [127:0] pat_k(input int k);
    return {4{32'hc0de0000 + 32'(k)}};
  endfunction

  task automatic step();
    @(negedge clk);
    #2;
  endtask

  localparam logic [127:0] FIPS_S = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] FIPS_K = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] FIPS_R = 128'h193de3bea0f4e22b9ac68d2ae9f84808;
  localparam logic [255:0] S8     =
    256'h00112233445566778899aabbccddeeff0f1e2d3c4b5a69788796a5b4c3d2e1f0;

  initial begin
    in_valid = 0; in_first = 0; bypass = 0; out_ready = 0; in_state = '0; in_key = '0;
    w_in_valid = 0; w_in_first = 0; w_bypass = 0; w_out_ready = 0;
    w_in_state = '0; w_in_key = '0;

    step(); step();
    check("rst_level",     level,     0);
    check("rst_in_ready",  in_ready,  1);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_state", out_state, 0);
    check("rst_err",       err,       0);
    reset = 1'b1;
    step();

    // FIPS-197 round 0
    in_valid = 1; in_first = 1; in_state = FIPS_S; in_key = FIPS_K;
    step();
    in_valid = 0; in_first = 0;
    check("fips_state", out_state, FIPS_R);
    check("fips_round", out_round, 0);
    check("fips_last",  out_last,  0);
    check("fips_level", level,     1);
    out_ready = 1;
    step();
    check("fips_drained", level, 0);

    // Full block, beat 5 in bypass
    for (int k = 0; k <= NR; k++) begin
      in_valid = 1; in_first = (k == 0); bypass = (k == 5);
      in_state = pat_s(k); in_key = pat_k(k);
      step();
      check("blk_round", out_round, k);
      check("blk_last",  out_last,  k == NR);
      check("blk_done",  done,      0);
      if (k == 5) check("blk_bypass", out_state, pat_s(5));
    end
    in_valid = 0; bypass = 0;
    step();
    check("blk_done_pulse", done,  1);
    check("blk_level",      level, 0);
    step();
    check("blk_done_clear", done, 0);

    // Continuation beat with no open block
    in_valid = 1; in_first = 0; in_state = pat_s(11); in_key = pat_k(11);
    step();
    in_valid = 0;
    check("seq_err",   err,       1);
    check("seq_round", out_round, 0);
    step();

    // Backpressure with DEPTH=2
    out_ready = 0;
    in_valid = 1; in_first = 1; in_state = pat_s(20); in_key = pat_k(20);
    step();
    in_first = 0; in_state = pat_s(21); in_key = pat_k(21);
    step();
    check("bp_full_level", level,    2);
    check("bp_full_ready", in_ready, 0);
    in_state = pat_s(22); in_key = pat_k(22);
    step();
    check("bp_level",      level,     2);
    check("bp_in_ready",   in_ready,  0);
    check("bp_head_state", out_state, pat_s(20) ^ pat_k(20));
    check("bp_head_round", out_round, 0);
    step();
    check("bp_stable_state", out_state, pat_s(20) ^ pat_k(20));
    check("bp_stable_round", out_round, 0);
    out_ready = 1;
    step();
    check("sim_full_pop_level", level,     1);
    check("sim_full_pop_round", out_round, 1);
    check("sim_full_pop_state", out_state, pat_s(21) ^ pat_k(21));
    step();
    check("sim_acc_pop_level", level,     1);
    check("sim_acc_pop_round", out_round, 2);
    check("sim_acc_pop_state", out_state, pat_s(22) ^ pat_k(22));
    in_valid = 0;
    step();
    check("bp_drained", level, 0);

    // NB=8: key all ones inverts; bypass passes through
    w_in_valid = 1; w_in_first = 1; w_in_state = S8; w_in_key = '1; w_out_ready = 1;
    step();
    check("w_not_state", w_out_state, ~S8);
    check("w_not_round", w_out_round, 0);
    w_bypass = 1; w_in_first = 0;
    step();
    check("w_pass_state", w_out_state, S8);
    check("w_pass_round", w_out_round, 1);
    w_in_valid = 0;
    step();
    check("w_level", w_level, 0);

    // Reset mid-block: exp=5, level=2
    for (int k = 0; k < 4; k++) begin
      in_valid = 1; in_first = (k == 0); in_state = pat_s(30 + k); in_key = pat_k(30 + k);
      step();
    end
    out_ready = 0; in_state = pat_s(34); in_key = pat_k(34);
    step();
    in_valid = 0;
    check("pre_rst_level", level,     2);
    check("pre_rst_round", out_round, 3);
    reset = 1'b0;
    #1;
    check("mid_rst_level",     level,     0);
    check("mid_rst_in_ready",  in_ready,  1);
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_out_state", out_state, 0);
    check("mid_rst_out_round", out_round, 0);
    check("mid_rst_out_last",  out_last,  0);
    check("mid_rst_done",      done,      0);
    check("mid_rst_err",       err,       0);
    step();
    reset = 1'b1;
    #1;
    check("post_rst_in_ready", in_ready, 1);
    in_valid = 1; in_first = 0; in_state = pat_s(40); in_key = pat_k(40);
    step();
    in_valid = 0;
    check("post_rst_round", out_round, 0);
    check("post_rst_err",   err,       1);
    check("post_rst_level", level,     1);
    out_ready = 1;
    step();
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/add_round_key_stream.md
# add_round_key_stream

Parametrised, streaming AddRoundKey stage for the Rijndael datapath. It XORs a state array with a round subkey under a valid/ready handshake and tags every result with its round index. A DEPTH-entry output buffer absorbs downstream backpressure. It sits between the MixColumns stage and the next SubBytes stage and supports block widths of 4–8 columns plus a key-bypass mode.

## Interface
- NB, 4, state columns (4..8); state and key are 4×NB bytes
- NR, 10, last round index of a block; round tags run 0..NR
- DEPTH, 2, output buffer entries (power of 2, ≥2)
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- in_valid  in  1  input beat present
- in_ready  out  1  stage can accept a beat; equals (level < DEPTH), no combinational path from out_ready
- in_state  in  [7:0][3:0][NB-1:0]  state bytes, indexed [row][col]
- in_key  in  [7:0][3:0][NB-1:0]  round subkey bytes, indexed [row][col]
- in_first  in  1  beat is round 0 of a new block
- bypass  in  1  pass in_state unchanged, ignoring in_key
- out_valid  out  1  buffer head valid
- out_ready  in  1  downstream accepts head
- out_state  out  [7:0][3:0][NB-1:0]  result at buffer head; all zero when empty
- out_round  out  $clog2(NR+1)  round tag of head; 0 when empty
- out_last  out  1  head tag == NR; 0 when empty
- done  out  1  one-cycle pulse after an out_last beat is popped
- err  out  1  sticky sequence error
- level  out  $clog2(DEPTH+1)  buffer occupancy

## Operation
- Result byte [r][c] = in_state[r][c] ^ in_key[r][c], or in_state[r][c] when bypass=1. Flattened form is a 32·NB-bit vector, column-major, with [0][0] in the MSB byte.
- Accept = in_valid && in_ready. Pop = out_valid && out_ready.
- Round tracker holds an idle flag (reset 1) and an expected round exp (reset 0). On each accept:
  - tag = 0 if in_first or idle; otherwise exp.
  - If tag == NR, set idle=1. Otherwise set exp = tag+1 and idle=0.
- Accept with in_first=0 while idle sets err=1 and tags the beat 0. err clears only on reset.
- in_first=1 mid-block aborts the current block and restarts at round 0. This is not an error.
- Buffer is a circular FIFO with read and write pointers wrapping modulo DEPTH. Order is strictly preserved.
- Simultaneous accept and pop: both happen and level is unchanged. When level==DEPTH there is no accept, even if a pop occurs in the same cycle.
- done is registered and is 1 in the cycle after any pop whose out_last=1.

## Timing
- Reset values (applied immediately while reset=0): level 0, in_ready 1, out_valid 0, out_state 0, out_round 0, out_last 0, done 0, err 0, idle 1, exp 0.
- Reset mid-operation flushes all buffered beats and discards the round position.
- Latency: a beat accepted at edge N is at the head with out_valid=1 after edge N when the buffer was empty. Otherwise it is behind older entries.
- Throughput: one beat per cycle when out_ready stays high.
- in_ready reflects the current level only and deasserts in the cycle level reaches DEPTH.
- Head outputs are stable while out_valid=1 and out_ready=0.

## Test plan
- **FIPS-197 round 0, NB=4.** Stimulus: in_state column-major 32 43 f6 a8 88 5a 30 8d 31 31 98 a2 e0 37 07 34, key 2b 7e 15 16 28 ae d2 a6 ab f7 15 88 09 cf 4f 3c, in_first=1. Required: next cycle out_state 19 3d e3 be a0 f4 e2 2b 9a c6 8d 2a e9 f8 48 08, out_round 0, out_last 0, level 1.
- **Full block sequence.** Stimulus: 11 back-to-back beats, first with in_first=1, out_ready=1. Required: tags 0..10; out_last=1 only on the 11th; done is a single pulse one cycle after it pops. Then a 12th beat with in_first=0 sets err=1 and is tagged 0.
- **Backpressure.** Stimulus: out_ready=0, push 3 beats with DEPTH=2. Required: beats 1–2 accepted; level=2 and in_ready=0 while beat 3 is held; state and tag at the head are stable. Then out_ready=1: beats drain in order, one per cycle, and beat 3 is accepted once level drops below 2.
- **Simultaneous events.** Stimulus: level=1, then accept and pop in the same cycle. Required: level stays 1 and the new beat becomes head next cycle. At level=2 with a pop and in_valid=1: the pop happens, no accept, level goes to 1.
- **Bypass and width.** Stimulus: NB=8 instance, key all ff, bypass=0. Required: out_state = bitwise NOT of in_state. Same beat with bypass=1: out_state = in_state.
- **Reset mid-operation.** Stimulus: level=2, mid-block at exp=5, pull reset low between edges. Required: all outputs are immediately at their reset values. After release, in_ready=1, and a beat with in_first=0 is tagged 0 and sets err=1.
